// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds bus widths, size codes, the IO address-decode constant and FSM encodings.
package mem_ctrl_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int BYTE_W = 8;

   typedef logic [ADDR_W-1:0] addr_bus_t;
   typedef logic [DATA_W-1:0] data_bus_t;
   typedef logic [BYTE_W-1:0] byte_bus_t;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   // mem_addr[17:16] value that selects the IO buffer region
   localparam logic [1:0] IO_REGION = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      IF_RD  = 2'b01,
      MEM_RD = 2'b10,
      MEM_WR = 2'b11
   } state_t;

   function automatic logic [2:0] byte_count(input logic [1:0] size);
      case (size)
         SIZE_BYTE: byte_count = 3'd1;
         SIZE_HALF: byte_count = 3'd2;
         default:   byte_count = 3'd4;
      endcase
   endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Arbitrates instruction fetch and load/store requests onto a byte-wide RAM,
// serialising each access one byte per cycle, little-endian.
module mem_ctrl
   import mem_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_data,
   output logic        if_done,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [1:0]  mem_size,
   output logic [31:0] mem_rdata,
   output logic        mem_done,
   input  logic        jump_enable_i,
   input  logic [7:0]  ram_din,
   output logic [7:0]  ram_dout,
   output logic [31:0] ram_a,
   output logic        ram_wr,
   input  logic        io_buffer_full,
   output logic        stall_req
);

   state_t      state_reg, state_next;
   logic [2:0]  cnt_reg;
   logic [2:0]  len_reg;
   data_bus_t   wdata_reg;
   data_bus_t   rd_buf_reg;
   data_bus_t   assembled;
   logic        io_blocked;
   logic        start_if;
   logic        start_mem;
   logic        last;

   // In a read state, cnt_reg = k+1 while RAM byte k is on ram_din.
   assign assembled = rd_buf_reg | ({24'd0, ram_din} << {cnt_reg - 3'd1, 3'd0});

   assign ram_wr    = (state_reg == MEM_WR) && rdy;
   assign stall_req = (state_reg != IDLE);

   always_comb begin
      state_next = state_reg;
      start_if   = 1'b0;
      start_mem  = 1'b0;
      last       = 1'b0;
      io_blocked = mem_req && mem_we && (mem_addr[17:16] == IO_REGION) && io_buffer_full;
      case (state_reg)
         IDLE: begin
            // A store held off by a full IO buffer also holds off fetches.
            if (io_blocked) begin
               state_next = IDLE;
            end else if (mem_req) begin
               start_mem  = 1'b1;
               state_next = mem_we ? MEM_WR : MEM_RD;
            end else if (if_req && !jump_enable_i) begin
               start_if   = 1'b1;
               state_next = IF_RD;
            end
         end
         IF_RD: begin
            if (jump_enable_i) begin
               state_next = IDLE;
            end else if (cnt_reg == len_reg) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         MEM_RD: begin
            if (cnt_reg == len_reg) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         MEM_WR: begin
            if (cnt_reg == len_reg - 3'd1) begin
               last       = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
      end else if (rdy) begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_reg    <= 3'd0;
         len_reg    <= 3'd0;
         wdata_reg  <= '0;
         rd_buf_reg <= '0;
         ram_a      <= '0;
         ram_dout   <= '0;
         if_data    <= '0;
         mem_rdata  <= '0;
         if_done    <= 1'b0;
         mem_done   <= 1'b0;
      end else if (rdy) begin
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         if (start_if || start_mem) begin
            cnt_reg    <= 3'd0;
            len_reg    <= start_mem ? byte_count(mem_size) : 3'd4;
            ram_a      <= start_mem ? mem_addr : if_addr;
            wdata_reg  <= mem_wdata;
            ram_dout   <= mem_wdata[7:0];
            rd_buf_reg <= '0;
         end else if (state_reg != IDLE) begin
            cnt_reg <= cnt_reg + 3'd1;
            if (cnt_reg + 3'd1 < len_reg) begin
               ram_a <= ram_a + 32'd1;
            end
            if (state_reg == MEM_WR) begin
               ram_dout  <= wdata_reg[15:8];
               wdata_reg <= wdata_reg >> 8;
            end else if (cnt_reg != 3'd0) begin
               rd_buf_reg <= assembled;
            end
            if (last) begin
               case (state_reg)
                  IF_RD: begin
                     if_data <= assembled;
                     if_done <= 1'b1;
                  end
                  MEM_RD: begin
                     mem_rdata <= assembled;
                     mem_done  <= 1'b1;
                  end
                  default: mem_done <= 1'b1;
               endcase
            end
         end
      end
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port rdy, input, 1; low freezes all state.
REQ-004 SHALL have ports if_req (in, 1) and if_addr (in, 32): instruction fetch request and word address.
REQ-005 SHALL have ports if_data (out, 32) and if_done (out, 1): the fetched instruction and its one-cycle completion pulse.
REQ-006 SHALL have ports mem_req, mem_we (in, 1), mem_addr, mem_wdata (in, 32) and mem_size (in, 2): load/store request; mem_size 00 = byte, 01 = half, 10 = word.
REQ-007 SHALL have ports mem_rdata (out, 32) and mem_done (out, 1): zero-extended load data and the completion pulse.
REQ-008 SHALL have port jump_enable_i (in, 1): control-flow redirect that flushes fetch.
REQ-009 SHALL have RAM ports ram_din (in, 8), ram_dout (out, 8), ram_a (out, 32) and ram_wr (out, 1; 1 = write).
REQ-010 SHALL have ports io_buffer_full (in, 1) and stall_req (out, 1; high whenever the FSM is not IDLE).

Function
REQ-011 SHALL implement FSM states IDLE, IF_RD, MEM_RD and MEM_WR, plus a 3-bit byte counter.
REQ-012 In IDLE, mem_req SHALL take priority over if_req; the request is accepted at edge T.
REQ-013 An accepted transaction SHALL run to completion with no preemption; new requests SHALL be sampled only in IDLE.
REQ-014 SHALL use byte count n = 1/2/4 for mem_size 00/01/10; fetch SHALL always use n = 4.
REQ-015 ram_a SHALL carry addr+k during cycle T+1+k, for k = 0..n-1.
REQ-016 Reads: RAM has 1-cycle latency; byte k SHALL be captured at the end of cycle T+2+k.
REQ-017 Reads: data SHALL be assembled little-endian (byte k into bits 8k+7:8k) with upper bytes zero.
REQ-018 Reads: done SHALL pulse high in cycle T+n+2, with data valid in that same cycle.
REQ-019 Writes: ram_dout SHALL carry mem_wdata byte k and ram_wr = 1 during cycle T+1+k.
REQ-020 Writes: mem_done SHALL pulse high in cycle T+n+1.
REQ-021 if_done and mem_done SHALL each be high for exactly one cycle per transaction; the FSM SHALL be back in IDLE during the done cycle.
REQ-022 jump_enable_i high during IF_RD SHALL abort the fetch: IDLE at the next edge, no if_done, stale bytes discarded.
REQ-023 jump_enable_i high in IDLE SHALL block acceptance of if_req that cycle.
REQ-024 jump_enable_i SHALL have no effect on a MEM_RD or MEM_WR transaction.
REQ-025 A store with mem_addr[17:16] = 2'b11 while io_buffer_full = 1 SHALL not be accepted and SHALL stay pending in IDLE.
REQ-026 if_req SHALL NOT be accepted while such a store (REQ-025) is pending.
REQ-027 rdy = 0 SHALL hold all registers, and ram_wr SHALL be forced to 0 combinationally so no write is duplicated.
REQ-028 ram_wr SHALL be 0 in every state other than MEM_WR.

Reset
REQ-029 rst = 0 SHALL immediately force state IDLE, counter 0, and all outputs (if_data, mem_rdata, done pulses, ram_a, ram_dout, ram_wr, stall_req) to 0.
REQ-030 Reset mid-transaction SHALL discard the transaction with no done pulse.
REQ-031 The first acceptance after reset SHALL occur no earlier than the first rising edge after rst returns to 1.

Structure
REQ-032 AddrBus, DataBus, ByteBus, the mem_size codes, the IO address-decode constant and the FSM state encodings SHALL live in the shared config.v.
REQ-033 The block SHALL be a single module with no sub-module; arbitration is three-way priority logic inside the FSM.

Verification
REQ-034 Word fetch: if_addr = 0x100, RAM bytes 13 05 00 00 -> if_data = 0x00000513 and if_done in cycle T+6.
REQ-035 Simultaneous if_req and mem_req (byte load at 0x200 = 0xFF) -> mem_done with mem_rdata = 0x000000FF at T+3; IF then accepted at T+3 with if_done at T+9.
REQ-036 Word store 0xDEADBEEF to 0x400 -> ram_wr high on cycles T+1..T+4 with ram_dout EF, BE, AD, DE at 0x400..0x403, and mem_done at T+5.
REQ-037 jump_enable_i pulsed at T+3 of a fetch -> no if_done, IDLE at T+4, and a new if_req accepted at T+4.
REQ-038 Byte store to 0x30000 with io_buffer_full = 1 for 5 cycles -> ram_wr stays 0 for those cycles, then the store is accepted and mem_done follows 2 cycles later.
REQ-039 rst dropped to 0 at T+2 of a word load -> outputs 0 immediately and no mem_done ever issued.
